// File: rtl/id_ctrl.sv
// Decode-stage controller for the 5-stage MIPS pipeline.
// This block decodes the instruction in IF/ID and drives the immediate
// extender select. It detects load-use and mult/div-busy hazards. It also
// owns the ID/EX control register, which loads a bubble on stall, kill,
// reset or an empty decode slot.
module id_ctrl #(
  parameter int unsigned MD_LAT = 8  // busy cycles after a mult/div issues (1..15)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  input  logic        valid_d,
  input  logic        kill_d,
  output logic [1:0]  ext_sel,
  output logic        stall_fd,
  output logic        e_valid,
  output logic [2:0]  e_alu_op,
  output logic        e_alu_src,
  output logic        e_reg_write,
  output logic        e_mem_read,
  output logic        e_mem_write,
  output logic [4:0]  e_wr_addr,
  output logic        e_md_start,
  output logic [1:0]  e_md_op
);

  localparam logic [3:0] MD_LAT_L = 4'(MD_LAT);

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_OR    = 3'd2;
  localparam logic [2:0] ALU_PASSB = 3'd3;

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign op    = instr_d[31:26];
  assign funct = instr_d[5:0];
  assign rs    = instr_d[25:21];
  assign rt    = instr_d[20:16];
  assign rd    = instr_d[15:11];

  // Decoded control word for the instruction currently in D
  logic [2:0] alu_op;
  logic       alu_src;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic [4:0] dest;
  logic       md_start;
  logic [1:0] md_op;
  logic       uses_rs;
  logic       uses_rt;
  logic       is_md;

  logic [3:0] md_cnt;
  logic       load_use;
  logic       md_hazard;
  logic       issue;

  // Instruction decode; unknown encodings fall through as a nop
  always_comb begin
    alu_op    = ALU_ADD;
    alu_src   = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    dest      = 5'd0;
    md_start  = 1'b0;
    md_op     = 2'd0;
    uses_rs   = 1'b0;
    uses_rt   = 1'b0;
    is_md     = 1'b0;
    ext_sel   = 2'd0;
    case (op)
      6'h00: begin
        case (funct)
          6'h21: begin alu_op = ALU_ADD; reg_write = 1'b1; dest = rd; uses_rs = 1'b1; uses_rt = 1'b1; end
          6'h23: begin alu_op = ALU_SUB; reg_write = 1'b1; dest = rd; uses_rs = 1'b1; uses_rt = 1'b1; end
          6'h08: begin uses_rs = 1'b1; end
          6'h18: begin md_start = 1'b1; md_op = 2'd0; is_md = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
          6'h1A: begin md_start = 1'b1; md_op = 2'd1; is_md = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
          6'h10: begin reg_write = 1'b1; dest = rd; md_op = 2'd2; is_md = 1'b1; end
          6'h12: begin reg_write = 1'b1; dest = rd; md_op = 2'd3; is_md = 1'b1; end
          default: ;
        endcase
      end
      6'h0D: begin alu_op = ALU_OR;    alu_src = 1'b1; reg_write = 1'b1; dest = rt; uses_rs = 1'b1; ext_sel = 2'd0; end
      6'h09: begin alu_op = ALU_ADD;   alu_src = 1'b1; reg_write = 1'b1; dest = rt; uses_rs = 1'b1; ext_sel = 2'd1; end
      6'h23: begin alu_op = ALU_ADD;   alu_src = 1'b1; reg_write = 1'b1; mem_read = 1'b1; dest = rt; uses_rs = 1'b1; ext_sel = 2'd1; end
      6'h2B: begin alu_op = ALU_ADD;   alu_src = 1'b1; mem_write = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; ext_sel = 2'd1; end
      6'h04: begin alu_op = ALU_SUB;   uses_rs = 1'b1; uses_rt = 1'b1; ext_sel = 2'd1; end
      6'h0F: begin alu_op = ALU_PASSB; alu_src = 1'b1; reg_write = 1'b1; dest = rt; ext_sel = 2'd2; end
      default: ;
    endcase
    // $0 is hardwired; a write to it is dropped here so EX/WB never see it
    if (dest == 5'd0) reg_write = 1'b0;
  end

  // Hazard detection and the resulting fetch/decode stall
  always_comb begin
    load_use  = e_valid & e_mem_read & (e_wr_addr != 5'd0) &
                ((uses_rs & (rs == e_wr_addr)) | (uses_rt & (rt == e_wr_addr)));
    md_hazard = (md_cnt != 4'd0) & is_md;
    stall_fd  = valid_d & ~kill_d & (load_use | md_hazard);
    issue     = valid_d & ~kill_d & ~stall_fd;
  end

  // ID/EX control register: issue the decoded word or load a bubble
  always_ff @(posedge clk) begin
    if (reset || !issue) begin
      e_valid     <= 1'b0;
      e_alu_op    <= 3'd0;
      e_alu_src   <= 1'b0;
      e_reg_write <= 1'b0;
      e_mem_read  <= 1'b0;
      e_mem_write <= 1'b0;
      e_wr_addr   <= 5'd0;
      e_md_start  <= 1'b0;
      e_md_op     <= 2'd0;
    end else begin
      e_valid     <= 1'b1;
      e_alu_op    <= alu_op;
      e_alu_src   <= alu_src;
      e_reg_write <= reg_write;
      e_mem_read  <= mem_read;
      e_mem_write <= mem_write;
      e_wr_addr   <= dest;
      e_md_start  <= md_start;
      e_md_op     <= md_op;
    end
  end

  // Mult/div busy countdown, reloaded whenever a mult/div issues
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= 4'd0;
    end else if (issue && md_start) begin
      md_cnt <= MD_LAT_L;
    end else if (md_cnt != 4'd0) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_id_ctrl.sv
// Directed testbench for id_ctrl with MD_LAT = 3. Each step drives D just
// after a rising edge, checks combinational outputs mid-cycle, and checks
// the ID/EX outputs just after the following edge.
module tb_id_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_d;
  logic        valid_d;
  logic        kill_d;
  logic [1:0]  ext_sel;
  logic        stall_fd;
  logic        e_valid;
  logic [2:0]  e_alu_op;
  logic        e_alu_src;
  logic        e_reg_write;
  logic        e_mem_read;
  logic        e_mem_write;
  logic [4:0]  e_wr_addr;
  logic        e_md_start;
  logic [1:0]  e_md_op;

  int tests = 0;
  int fails = 0;

  id_ctrl #(.MD_LAT(3)) dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .valid_d(valid_d), .kill_d(kill_d),
    .ext_sel(ext_sel), .stall_fd(stall_fd), .e_valid(e_valid), .e_alu_op(e_alu_op),
    .e_alu_src(e_alu_src), .e_reg_write(e_reg_write), .e_mem_read(e_mem_read),
    .e_mem_write(e_mem_write), .e_wr_addr(e_wr_addr), .e_md_start(e_md_start),
    .e_md_op(e_md_op)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int funct);
    rtype = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
    itype = {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [15:0] eword();
    eword = {e_valid, e_alu_op, e_alu_src, e_reg_write, e_mem_read, e_mem_write,
             e_wr_addr, e_md_start, e_md_op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins);
    instr_d = ins;
    valid_d = 1'b1;
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    instr_d = 32'd0;
    valid_d = 1'b0;
    kill_d  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_eword", 32'(eword()), 32'd0);
    chk("reset_mdcnt", 32'(dut.md_cnt), 32'd0);

    // ALU mix
    drive(itype(6'h0D, 0, 1, 16'hFFFF));            // ori $1,$0,0xFFFF
    chk("ori_ext", 32'(ext_sel), 32'd0);
    chk("ori_stall", 32'(stall_fd), 32'd0);
    tick();
    chk("ori_valid", 32'(e_valid), 32'd1);
    chk("ori_aluop", 32'(e_alu_op), 32'd2);
    chk("ori_alusrc", 32'(e_alu_src), 32'd1);
    chk("ori_wr", 32'(e_wr_addr), 32'd1);
    chk("ori_rw", 32'(e_reg_write), 32'd1);

    drive(itype(6'h0F, 0, 2, 16'h1234));            // lui $2,0x1234
    chk("lui_ext", 32'(ext_sel), 32'd2);
    tick();
    chk("lui_aluop", 32'(e_alu_op), 32'd3);
    chk("lui_wr", 32'(e_wr_addr), 32'd2);

    drive(itype(6'h09, 1, 3, 5));                   // addiu $3,$1,5
    chk("addiu_ext", 32'(ext_sel), 32'd1);
    tick();
    chk("addiu_aluop", 32'(e_alu_op), 32'd0);
    chk("addiu_alusrc", 32'(e_alu_src), 32'd1);

    // MD busy: mult then mflo held for 3 cycles
    drive(rtype(1, 2, 0, 6'h18));                   // mult $1,$2
    chk("mult_stall", 32'(stall_fd), 32'd0);
    tick();
    chk("mult_start", 32'(e_md_start), 32'd1);
    chk("mult_mdop", 32'(e_md_op), 32'd0);
    chk("mult_rw", 32'(e_reg_write), 32'd0);
    drive(rtype(0, 0, 3, 6'h12));                   // mflo $3
    for (int i = 0; i < 3; i++) begin
      chk("mflo_stall", 32'(stall_fd), 32'd1);
      tick();
      chk("mflo_bubble", 32'(e_valid), 32'd0);
    end
    chk("mflo_release", 32'(stall_fd), 32'd0);
    tick();
    chk("mflo_valid", 32'(e_valid), 32'd1);
    chk("mflo_mdop", 32'(e_md_op), 32'd3);
    chk("mflo_wr", 32'(e_wr_addr), 32'd3);

    // Independent addu inside the busy window, then mfhi waits out the rest
    drive(rtype(1, 2, 0, 6'h18));                   // mult $1,$2
    tick();
    drive(rtype(1, 2, 4, 6'h21));                   // addu $4,$1,$2
    chk("addu_md_nostall", 32'(stall_fd), 32'd0);
    tick();
    chk("addu_md_valid", 32'(e_valid), 32'd1);
    chk("addu_md_wr", 32'(e_wr_addr), 32'd4);
    drive(rtype(0, 0, 7, 6'h10));                   // mfhi $7
    for (int i = 0; i < 2; i++) begin
      chk("mfhi_stall", 32'(stall_fd), 32'd1);
      tick();
    end
    chk("mfhi_release", 32'(stall_fd), 32'd0);
    tick();
    chk("mfhi_mdop", 32'(e_md_op), 32'd2);

    // Load-use: lw $5,0($2); addu $6,$5,$7
    drive(itype(6'h23, 2, 5, 0));
    chk("lw_ext", 32'(ext_sel), 32'd1);
    tick();
    chk("lw_memrd", 32'(e_mem_read), 32'd1);
    chk("lw_wr", 32'(e_wr_addr), 32'd5);
    drive(rtype(5, 7, 6, 6'h21));
    chk("lu_stall", 32'(stall_fd), 32'd1);
    tick();
    chk("lu_bubble", 32'(e_valid), 32'd0);
    chk("lu_release", 32'(stall_fd), 32'd0);
    tick();
    chk("lu_addu_valid", 32'(e_valid), 32'd1);
    chk("lu_addu_wr", 32'(e_wr_addr), 32'd6);

    // Load into $0 never causes a stall
    drive(itype(6'h23, 2, 0, 0));                   // lw $0,0($2)
    tick();
    drive(rtype(0, 7, 6, 6'h21));                   // addu $6,$0,$7
    chk("lw0_nostall", 32'(stall_fd), 32'd0);
    tick();
    chk("lw0_valid", 32'(e_valid), 32'd1);

    // Consumer that does not read the loaded register
    drive(itype(6'h23, 2, 5, 0));                   // lw $5,0($2)
    tick();
    drive(itype(6'h0D, 0, 6, 1));                   // ori $6,$0,1
    chk("ori_nostall", 32'(stall_fd), 32'd0);
    tick();
    chk("ori_lu_aluop", 32'(e_alu_op), 32'd2);

    // Kill overrides a load-use stall
    drive(itype(6'h23, 2, 5, 0));
    tick();
    instr_d = rtype(5, 7, 6, 6'h21);
    kill_d  = 1'b1;
    #1;
    chk("kill_stall", 32'(stall_fd), 32'd0);
    tick();
    chk("kill_bubble", 32'(e_valid), 32'd0);
    kill_d = 1'b0;

    // Reset while md_cnt = 2 and EX valid
    drive(rtype(1, 2, 0, 6'h18));                   // mult
    tick();
    drive(rtype(1, 2, 4, 6'h21));                   // addu $4,$1,$2
    tick();
    chk("pre_rst_mdcnt", 32'(dut.md_cnt), 32'd2);
    chk("pre_rst_valid", 32'(e_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_eword", 32'(eword()), 32'd0);
    chk("rst_mdcnt", 32'(dut.md_cnt), 32'd0);
    drive(rtype(0, 0, 3, 6'h12));                   // mflo $3
    chk("rst_mflo_nostall", 32'(stall_fd), 32'd0);
    tick();
    chk("rst_mflo_valid", 32'(e_valid), 32'd1);

    // Unknown opcode 0x3F, rt = 4: valid nop
    drive(itype(6'h3F, 1, 4, 16'h8000));
    chk("unk_ext", 32'(ext_sel), 32'd0);
    tick();
    chk("unk_valid", 32'(e_valid), 32'd1);
    chk("unk_enables", 32'({e_alu_src, e_reg_write, e_mem_read, e_mem_write, e_md_start}), 32'd0);

    // Write to $0 is dropped
    drive(rtype(1, 2, 0, 6'h21));                   // addu $0,$1,$2
    tick();
    chk("r0_valid", 32'(e_valid), 32'd1);
    chk("r0_rw", 32'(e_reg_write), 32'd0);

    // Store
    drive(itype(6'h2B, 2, 5, 4));                   // sw $5,4($2)
    chk("sw_ext", 32'(ext_sel), 32'd1);
    tick();
    chk("sw_memwr", 32'(e_mem_write), 32'd1);
    chk("sw_rw", 32'(e_reg_write), 32'd0);

    // Empty slot becomes a bubble
    valid_d = 1'b0;
    tick();
    chk("novalid_eword", 32'(eword()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ctrl.md
Name: id_ctrl

Overview:
- Decode-stage controller for the 5-stage MIPS pipeline.
- Decodes the instruction held in IF/ID and drives the immediate extender select: 0 = zero-extend, 1 = sign-extend, 2 = shift into upper half.
- Detects load-use and multiply/divide-busy hazards, and stalls fetch/decode when either is present.
- Owns the ID/EX control pipeline register: inserts bubbles on stall or kill, otherwise issues the decoded control word to EX.

Parameters:
- MD_LAT, 8: cycles the mult/div unit stays busy after a mult/div issues to EX. Legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- instr_d  input  32  instruction in IF/ID.
- valid_d  input  1  instr_d holds a real instruction.
- kill_d  input  1  redirect from a later stage; discard the instruction in D this cycle.
- ext_sel  output  2  combinational select to the extender for instr_d.
- stall_fd  output  1  combinational; hold PC and IF/ID this cycle.
- e_valid  output  1  registered; EX holds a real instruction.
- e_alu_op  output  3  registered; 0 = ADD, 1 = SUB, 2 = OR, 3 = PASSB.
- e_alu_src  output  1  registered; 1 = ALU B operand is the extended immediate.
- e_reg_write  output  1  registered; register-file write enable.
- e_mem_read  output  1  registered.
- e_mem_write  output  1  registered.
- e_wr_addr  output  5  registered; destination register (rd for R-type, rt for I-type).
- e_md_start  output  1  registered; mult/div issued this cycle.
- e_md_op  output  2  registered; 0 = mult, 1 = div, 2 = mfhi, 3 = mflo.

Behaviour:
- Decode. op = instr_d[31:26], funct = [5:0], rs = [25:21], rt = [20:16], rd = [15:11].
  - R-type (op 0), by funct:
    - addu 0x21: ADD, reg_write, uses rs and rt.
    - subu 0x23: SUB, reg_write, uses rs and rt.
    - jr 0x08: no write, uses rs.
    - mult 0x18 and div 0x1A: md_start, uses rs and rt.
    - mfhi 0x10 and mflo 0x12: reg_write to rd, md_op 2 or 3, no GPR read.
  - I-type, by op:
    - ori 0x0D: OR, alu_src, ext_sel 0.
    - addiu 0x09: ADD, alu_src, ext_sel 1.
    - lw 0x23: ADD, alu_src, mem_read, ext_sel 1.
    - sw 0x2B: ADD, alu_src, mem_write, ext_sel 1, uses rt.
    - beq 0x04: SUB, ext_sel 1, uses rt.
    - lui 0x0F: PASSB, alu_src, ext_sel 2.
  - All I-type uses rs except lui. reg_write applies to ori, addiu, lw and lui, with destination rt.
  - Unknown opcode or funct: ext_sel 0, decoded as a nop (all enables 0). No exception.
  - A destination of register 0 forces reg_write to 0.
- Load-use hazard: e_valid & e_mem_read & e_wr_addr != 0 & ((uses_rs & rs == e_wr_addr) | (uses_rt & rt == e_wr_addr)).
- MD hazard: md_cnt != 0 & D holds mult, div, mfhi or mflo.
- stall_fd = valid_d & ~kill_d & (load-use hazard | MD hazard). A kill always overrides a stall.
- ID/EX register update each cycle:
  - If reset, stall_fd, kill_d or ~valid_d: load a bubble. All e_* outputs become 0, including e_valid.
  - Otherwise: load the decoded word with e_valid = 1.
- md_cnt (4 bits, internal):
  - reset clears it to 0.
  - When a mult/div issues (a non-bubble load with md_start set), it loads MD_LAT.
  - Otherwise it decrements while non-zero.
  - If an issue coincides with a non-zero count it reloads MD_LAT; this cannot happen because of the stall, but it is the defined behaviour.
- Latency:
  - ext_sel and stall_fd are 0-cycle combinational.
  - The control word appears on e_* one clock after D accepts the instruction.
  - A load-use stall lasts exactly 1 cycle.
  - An MD stall releases on the first cycle md_cnt reads 0.
- Reset mid-operation: all e_* and md_cnt are 0 on the next edge. stall_fd may assert combinationally during reset; downstream ignores it.

Test Plan:
- ALU mix (requires MD_LAT = 3 for the mult issued at the end):
  - Issue ori $1,$0,0xFFFF. Required: ext_sel = 0; next cycle e_valid = 1, e_alu_op = 2, e_alu_src = 1, e_wr_addr = 1.
  - Issue lui. Required: ext_sel = 2.
  - Issue addiu. Required: ext_sel = 1.
  - Issue mult. Required: e_md_start = 1, e_md_op = 0, e_reg_write = 0.
- Load-use: lw $5,0($2) then addu $6,$5,$7.
  - Required: stall_fd = 1 for exactly one cycle and e_valid = 0 for that cycle; addu reaches EX one cycle later.
  - Repeat with lw $0 as the load, or with the consumer ori $6,$0,1 (which does not read $5). Required: no stall in either case.
- MD busy, MD_LAT = 3: mult $1,$2, then mflo $3 immediately.
  - Required: stall_fd held for 3 cycles; mflo issues with e_md_op = 3 and e_wr_addr = 3.
  - An independent addu in the same window does not stall.
- Kill during stall: lw $5 in EX, addu using $5 in D, kill_d = 1 in the same cycle.
  - Required: stall_fd = 0; next cycle e_valid = 0.
- Reset: assert reset while md_cnt = 2 and e_valid = 1.
  - Required: next edge all e_* = 0 and md_cnt = 0; a following mflo does not stall.
- Unknown opcode 0x3F, rt = 4: ext_sel = 0; e_valid = 1 with all enables 0. Also issue a write to register 0 (addu $0,$1,$2) and confirm e_reg_write = 0.
